// File: rtl/vj_frame_scheduler.sv
// Ping-pong scheduler for two integral-image banks.
// Builder fills one bank while the detector reads the other.
module vj_frame_scheduler #(
    parameter int TIMEOUT_W = 20,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             cam_frame_start,
    output logic             bld_frame_start,
    input  logic             bld_frame_done,
    output logic             wr_bank,
    output logic             det_start,
    output logic             det_bank,
    input  logic             det_done,
    output logic             frame_drop,
    output logic             build_timeout,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic             idle
);

    typedef enum logic [1:0] {
        B_EMPTY,
        B_BUILDING,
        B_FULL,
        B_READING
    } bank_e;

    typedef enum logic {
        W_IDLE,
        W_BUILD
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_RUN
    } rstate_e;

    // Last watchdog value before the all-ones abort point.
    localparam logic [TIMEOUT_W-1:0] WD_LAST =
        {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    wstate_e              w_q, w_nx;
    rstate_e              r_q, r_nx;
    bank_e [1:0]          bank_q, bank_d;
    logic                 last_wr;
    logic [TIMEOUT_W-1:0] wd_q;

    logic                 cam;
    logic                 w_go, w_tgt, w_fin, w_abort;
    logic [1:0]           w_drop;
    logic                 r_go, r_pick, r_fin;
    logic [CNT_W:0]       drop_sum;
    logic [CNT_W-1:0]     drop_nx;

    assign cam = cam_frame_start & enable;

    // Writer: pick a target bank on frame start, watch the build.
    always_comb begin
        w_nx    = w_q;
        w_go    = 1'b0;
        w_tgt   = ~last_wr;
        w_fin   = 1'b0;
        w_abort = 1'b0;
        w_drop  = 2'd0;
        unique case (w_q)
            W_IDLE: begin
                if (cam) begin
                    w_go  = 1'b1;
                    w_tgt = (r_q == R_RUN) ? ~det_bank : ~last_wr;
                    if (bank_q[w_tgt] == B_FULL)
                        w_drop = 2'd1;
                    w_nx = W_BUILD;
                end
            end
            W_BUILD: begin
                if (cam)
                    w_drop = 2'd1;
                if (bld_frame_done) begin
                    w_fin = 1'b1;
                    w_nx  = W_IDLE;
                end else if (wd_q == WD_LAST) begin
                    w_abort = 1'b1;
                    w_drop  = w_drop + 2'd1;
                    w_nx    = W_IDLE;
                end
            end
            default: w_nx = W_IDLE;
        endcase
    end

    // Reader: claim a FULL bank when idle, release it on det_done.
    always_comb begin
        r_nx   = r_q;
        r_go   = 1'b0;
        r_pick = 1'b0;
        r_fin  = 1'b0;
        unique case (r_q)
            R_IDLE: begin
                if (bank_q[0] == B_FULL && bank_q[1] == B_FULL) begin
                    r_go   = 1'b1;
                    r_pick = ~last_wr;
                end else if (bank_q[0] == B_FULL) begin
                    r_go   = 1'b1;
                    r_pick = 1'b0;
                end else if (bank_q[1] == B_FULL) begin
                    r_go   = 1'b1;
                    r_pick = 1'b1;
                end
                if (r_go)
                    r_nx = R_RUN;
            end
            R_RUN: begin
                if (det_done) begin
                    r_fin = 1'b1;
                    r_nx  = R_IDLE;
                end
            end
            default: r_nx = R_IDLE;
        endcase
    end

    // Bank state update; a new build claim is applied last.
    always_comb begin
        bank_d = bank_q;
        if (w_fin)
            bank_d[wr_bank] = B_FULL;
        if (w_abort)
            bank_d[wr_bank] = B_EMPTY;
        if (r_fin)
            bank_d[det_bank] = B_EMPTY;
        if (r_go)
            bank_d[r_pick] = B_READING;
        if (w_go)
            bank_d[w_tgt] = B_BUILDING;
    end

    // Saturating drop counter; up to two drops per cycle.
    always_comb begin
        drop_sum = {1'b0, drop_cnt}
                 + {{(CNT_W-1){1'b0}}, w_drop};
        drop_nx  = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // FSM state and bank state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_q    <= W_IDLE;
            r_q    <= R_IDLE;
            bank_q <= {B_EMPTY, B_EMPTY};
        end else begin
            w_q    <= w_nx;
            r_q    <= r_nx;
            bank_q <= bank_d;
        end
    end

    // Registered outputs, bank selects, watchdog and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bld_frame_start <= 1'b0;
            det_start       <= 1'b0;
            frame_drop      <= 1'b0;
            build_timeout   <= 1'b0;
            wr_bank         <= 1'b0;
            det_bank        <= 1'b0;
            last_wr         <= 1'b1;
            wd_q            <= '0;
            drop_cnt        <= '0;
            done_cnt        <= '0;
        end else begin
            bld_frame_start <= w_go;
            det_start       <= r_go;
            frame_drop      <= |w_drop;
            build_timeout   <= w_abort;
            drop_cnt        <= drop_nx;
            if (w_go) begin
                wr_bank <= w_tgt;
                last_wr <= w_tgt;
            end
            if (r_go)
                det_bank <= r_pick;
            if (w_go)
                wd_q <= '0;
            else if (w_q == W_BUILD)
                wd_q <= wd_q + 1'b1;
            if (r_fin && done_cnt != '1)
                done_cnt <= done_cnt + 1'b1;
        end
    end

    assign idle = (w_q == W_IDLE) && (r_q == R_IDLE)
               && (bank_q[0] != B_FULL)
               && (bank_q[1] != B_FULL);

endmodule

// File: tb/tb_vj_frame_scheduler.sv
// Bench for vj_frame_scheduler: directed scenarios plus
// random traffic against a bank-level behavioural model.
module tb_vj_frame_scheduler;

    localparam int TW   = 4;
    localparam int CW   = 4;
    localparam int TMO  = (1 << TW) - 1;
    localparam int CMAX = (1 << CW) - 1;

    localparam int EMPTY = 0;
    localparam int BUILD = 1;
    localparam int FULL  = 2;
    localparam int READ  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          cam = 1'b0;
    logic          bdone = 1'b0;
    logic          ddone = 1'b0;
    logic          bfs, wr_bank, ds, det_bank;
    logic          fdrop, btmo, idle;
    logic [CW-1:0] dropc, donec;

    always #5 clk = ~clk;

    vj_frame_scheduler #(
        .TIMEOUT_W(TW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .cam_frame_start(cam),
        .bld_frame_start(bfs),
        .bld_frame_done(bdone),
        .wr_bank(wr_bank),
        .det_start(ds),
        .det_bank(det_bank),
        .det_done(ddone),
        .frame_drop(fdrop),
        .build_timeout(btmo),
        .drop_cnt(dropc),
        .done_cnt(donec),
        .idle(idle)
    );

    int vecs = 0;
    int errs = 0;

    // Model: bank states, who is busy, and the pulses due next.
    int mb[2];
    bit m_wbusy, m_rbusy;
    int m_last, m_wr, m_det, m_age;
    bit m_bfs, m_ds, m_drop, m_to;
    int m_dropc, m_donec;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mb[0] = EMPTY;
        mb[1] = EMPTY;
        m_wbusy = 0;
        m_rbusy = 0;
        m_last = 1;
        m_wr = 0;
        m_det = 0;
        m_age = 0;
        m_bfs = 0;
        m_ds = 0;
        m_drop = 0;
        m_to = 0;
        m_dropc = 0;
        m_donec = 0;
    endtask

    task automatic model_step(input bit c, input bit b,
                              input bit d);
        int nb[2];
        int drops;
        int tgt;
        int pick;
        bit go_w;
        nb = mb;
        drops = 0;
        tgt = 0;
        go_w = 0;
        m_bfs = 0;
        m_ds = 0;
        m_to = 0;
        if (!m_wbusy) begin
            if (c) begin
                tgt = m_rbusy ? 1 - m_det : 1 - m_last;
                if (mb[tgt] == FULL)
                    drops++;
                go_w = 1;
            end
        end else begin
            if (c)
                drops++;
            if (b) begin
                nb[m_wr] = FULL;
                m_wbusy = 0;
            end else if (m_age == TMO - 1) begin
                nb[m_wr] = EMPTY;
                m_wbusy = 0;
                m_to = 1;
                drops++;
            end else begin
                m_age++;
            end
        end
        if (!m_rbusy) begin
            pick = -1;
            if (mb[0] == FULL && mb[1] == FULL)
                pick = 1 - m_last;
            else if (mb[0] == FULL)
                pick = 0;
            else if (mb[1] == FULL)
                pick = 1;
            if (pick >= 0) begin
                nb[pick] = READ;
                m_rbusy = 1;
                m_det = pick;
                m_ds = 1;
            end
        end else if (d) begin
            nb[m_det] = EMPTY;
            m_rbusy = 0;
            if (m_donec < CMAX)
                m_donec++;
        end
        if (go_w) begin
            nb[tgt] = BUILD;
            m_wr = tgt;
            m_last = tgt;
            m_wbusy = 1;
            m_age = 0;
            m_bfs = 1;
        end
        m_drop = (drops > 0);
        m_dropc = m_dropc + drops;
        if (m_dropc > CMAX)
            m_dropc = CMAX;
        mb = nb;
    endtask

    function automatic bit m_idle();
        return !m_wbusy && !m_rbusy
            && mb[0] != FULL && mb[1] != FULL;
    endfunction

    task automatic compare_all();
        chk("bld_frame_start", bfs, m_bfs);
        chk("wr_bank", wr_bank, m_wr);
        chk("det_start", ds, m_ds);
        chk("det_bank", det_bank, m_det);
        chk("frame_drop", fdrop, m_drop);
        chk("build_timeout", btmo, m_to);
        chk("drop_cnt", dropc, m_dropc);
        chk("done_cnt", donec, m_donec);
        chk("idle", idle, m_idle());
    endtask

    // Called at a falling edge; returns at the next one.
    task automatic tick(input bit c, input bit b, input bit d);
        cam = c;
        bdone = b;
        ddone = d;
        model_step(c && enable, b, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        cam = 0;
        bdone = 0;
        ddone = 0;
        reset_n = 0;
        #1;
        model_reset();
        chk("rst bld_frame_start", bfs, 0);
        chk("rst det_start", ds, 0);
        chk("rst frame_drop", fdrop, 0);
        chk("rst build_timeout", btmo, 0);
        chk("rst wr_bank", wr_bank, 0);
        chk("rst det_bank", det_bank, 0);
        chk("rst drop_cnt", dropc, 0);
        chk("rst done_cnt", donec, 0);
        chk("rst idle", idle, 1);
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        enable = 1;
        for (int i = 0; i < 3; i++)
            tick(0, 0, 0);

        // First frame into bank 0, detect two cycles after done.
        tick(1, 0, 0);
        chk("t1 bfs", bfs, 1);
        chk("t1 wr_bank", wr_bank, 0);
        chk("t1 idle", idle, 0);
        for (int i = 0; i < 3; i++)
            tick(0, 0, 0);
        tick(0, 1, 0);
        chk("t1 det_start early", ds, 0);
        tick(0, 0, 0);
        chk("t1 det_start", ds, 1);
        chk("t1 det_bank", det_bank, 0);

        // Second frame goes to bank 1 while bank 0 is read.
        tick(1, 0, 0);
        chk("t2 bfs", bfs, 1);
        chk("t2 wr_bank", wr_bank, 1);
        tick(0, 0, 0);
        tick(0, 1, 0);
        chk("t2 det_start", ds, 0);

        // Overrun onto pending bank 1.
        tick(1, 0, 0);
        chk("t3 bfs", bfs, 1);
        chk("t3 wr_bank", wr_bank, 1);
        chk("t3 frame_drop", fdrop, 1);
        chk("t3 drop_cnt", dropc, 1);
        chk("t3 det_bank", det_bank, 0);

        // Frame start while building is dropped.
        tick(1, 0, 0);
        chk("t4 bfs", bfs, 0);
        chk("t4 frame_drop", fdrop, 1);
        chk("t4 drop_cnt", dropc, 2);
        tick(0, 0, 0);
        chk("t4 drop pulse end", fdrop, 0);

        // Build done and detect done together.
        tick(0, 1, 1);
        chk("t6 done_cnt", donec, 1);
        chk("t6 det_start early", ds, 0);
        tick(0, 0, 0);
        chk("t6 det_start", ds, 1);
        chk("t6 det_bank", det_bank, 1);
        tick(0, 0, 1);
        chk("t6 done_cnt 2", donec, 2);
        chk("t6 idle", idle, 1);

        // Watchdog abort 15 cycles after the build pulse.
        tick(1, 0, 0);
        chk("t5 bfs", bfs, 1);
        chk("t5 wr_bank", wr_bank, 0);
        for (int i = 1; i < 15; i++) begin
            tick(0, 0, 0);
            chk("t5 no timeout", btmo, 0);
        end
        tick(0, 0, 0);
        chk("t5 build_timeout", btmo, 1);
        chk("t5 drop_cnt", dropc, 3);
        chk("t5 idle", idle, 1);

        // Disabled frame starts are ignored.
        enable = 0;
        tick(1, 0, 0);
        chk("en0 bfs", bfs, 0);
        chk("en0 drop_cnt", dropc, 3);
        enable = 1;
        tick(1, 0, 0);
        chk("t5 restart bfs", bfs, 1);
        chk("t5 restart wr_bank", wr_bank, 1);

        // Drop counter saturates.
        for (int i = 0; i < 20; i++)
            tick(1, 0, 0);
        chk("sat drop_cnt", dropc, CMAX);

        // Mid-stream reset.
        do_reset();

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            bit c, b, d;
            c = ($urandom_range(0, 11) == 0);
            if (m_wbusy)
                b = ($urandom_range(0, 5) == 0);
            else
                b = ($urandom_range(0, 49) == 0);
            if (m_rbusy)
                d = ($urandom_range(0, 4) == 0);
            else
                d = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0)
                enable = ~enable;
            if ($urandom_range(0, 999) == 0)
                do_reset();
            else
                tick(c, b, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
